// File: rtl/ram_loader_pkg.sv
// Shared constants for the serial RAM loader: FSM state codes, default
// command bytes and the sizing rule for the inter-byte timeout counter.
package ram_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AHI  = 3'd1;
  localparam logic [2:0] ST_ALO  = 3'd2;
  localparam logic [2:0] ST_LHI  = 3'd3;
  localparam logic [2:0] ST_LLO  = 3'd4;
  localparam logic [2:0] ST_DATA = 3'd5;

  localparam logic [7:0] CMD_LOAD_DEFAULT = 8'h4C;
  localparam logic [7:0] CMD_RUN_DEFAULT  = 8'h52;
  localparam logic [7:0] CMD_HALT_DEFAULT = 8'h48;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  // Bits needed to hold every value from 0 up to and including the limit.
  function automatic int timeout_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream in, CPU bus in, RAM port out. The loader is the slave side;
// whoever feeds bytes and CPU cycles (and watches the RAM port) is the master.
interface ram_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;

  modport master (
    output rx_data, rx_valid, cpu_addr, cpu_we, cpu_dout,
    input  ram_addr, ram_we, ram_din
  );

  modport slave (
    input  rx_data, rx_valid, cpu_addr, cpu_we, cpu_dout,
    output ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/ram_loader.sv
// Serial program loader: decodes L/R/H command bytes, writes framed images
// into RAM while the 65C02 is held in reset, then hands the RAM port back.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter bit          BOOT_HOLD      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0]  CMD_LOAD       = CMD_LOAD_DEFAULT,
  parameter logic [7:0]  CMD_RUN        = CMD_RUN_DEFAULT,
  parameter logic [7:0]  CMD_HALT       = CMD_HALT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  ram_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        busy,
  output logic        load_done,
  output logic        err
);

  localparam int TW = timeout_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [2:0]    state;
  logic [15:0]   ptr;
  logic [15:0]   cnt;
  logic          wr_en;
  logic [15:0]   wr_addr;
  logic [7:0]    wr_data;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [15:0]   len_next;

  // Abort on the last idle cycle of the window; a byte arriving in that
  // same cycle wins and is accepted instead.
  assign tmo_hit  = (state != ST_IDLE) && !bus.rx_valid && (tmo_cnt >= TMO_LAST);
  assign len_next = {cnt[15:8], bus.rx_data};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      tmo_cnt   <= '0;
      cpu_reset <= BOOT_HOLD;
      load_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;

      if (state == ST_IDLE || bus.rx_valid)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) begin
        err   <= 1'b1;
        state <= ST_IDLE;
      end else if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == CMD_LOAD) begin
              if (cpu_reset) state <= ST_AHI;
              else           err   <= 1'b1;
            end else if (bus.rx_data == CMD_RUN) begin
              cpu_reset <= 1'b0;
            end else if (bus.rx_data == CMD_HALT) begin
              cpu_reset <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          ST_AHI: begin
            ptr[15:8] <= bus.rx_data;
            state     <= ST_ALO;
          end
          ST_ALO: begin
            ptr[7:0] <= bus.rx_data;
            state    <= ST_LHI;
          end
          ST_LHI: begin
            cnt[15:8] <= bus.rx_data;
            state     <= ST_LLO;
          end
          ST_LLO: begin
            cnt   <= len_next;
            state <= (len_next == 16'h0000) ? ST_IDLE : ST_DATA;
          end
          ST_DATA: begin
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= bus.rx_data;
            ptr     <= ptr + 16'd1;
            cnt     <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              load_done <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // While the CPU runs, the RAM port is a pure combinational passthrough.
  assign bus.ram_addr = cpu_reset ? wr_addr : bus.cpu_addr;
  assign bus.ram_we   = cpu_reset ? wr_en   : bus.cpu_we;
  assign bus.ram_din  = cpu_reset ? wr_data : bus.cpu_dout;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: boot load, run/halt mux, wrap, zero length,
// timeout, simultaneous byte/timeout and reset in the middle of a frame.
module tb_ram_loader;

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset;
  logic busy;
  logic load_done;
  logic err;
  int   checks = 0;
  int   failures = 0;

  ram_loader_if bus();

  ram_loader #(
    .BOOT_HOLD      (1'b1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one cycle; on return the cycle after it is observable.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.cpu_addr = 16'h1234;
    bus.cpu_we   = 1'b1;
    bus.cpu_dout = 8'h99;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tick();
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (load_done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", load_done, err); end
    bus.cpu_we = 1'b0;
  endtask

  task automatic test_boot_load();
    logic [7:0] hdr [5];
    logic [7:0] dat [3];
    hdr = '{8'h4C, 8'hC0, 8'h00, 8'h00, 8'h03};
    dat = '{8'hEA, 8'hA0, 8'h00};
    for (int i = 0; i < 5; i++) begin
      send_byte(hdr[i]);
      checks++; if (busy !== 1'b1 || bus.ram_we !== 1'b0) begin failures++; $display("FAIL boot_hdr[%0d] busy=%b we=%b exp busy=1 we=0", i, busy, bus.ram_we); end
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(dat[i]);
      checks++; if (bus.ram_we !== 1'b1) begin failures++; $display("FAIL boot_we[%0d] got=%b exp=1", i, bus.ram_we); end
      checks++; if (bus.ram_addr !== 16'hC000 + 16'(i)) begin failures++; $display("FAIL boot_addr[%0d] got=%h exp=%h", i, bus.ram_addr, 16'hC000 + 16'(i)); end
      checks++; if (bus.ram_din !== dat[i]) begin failures++; $display("FAIL boot_din[%0d] got=%h exp=%h", i, bus.ram_din, dat[i]); end
      checks++; if (load_done !== (i == 2)) begin failures++; $display("FAIL boot_done[%0d] got=%b exp=%b", i, load_done, (i == 2)); end
      checks++; if (busy !== (i != 2)) begin failures++; $display("FAIL boot_busy[%0d] got=%b exp=%b", i, busy, (i != 2)); end
    end
    tick();
    checks++; if (bus.ram_we !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL boot_after we=%b done=%b exp 0 0", bus.ram_we, load_done); end
  endtask

  task automatic test_run_mux();
    send_byte(8'h52);
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL run_cpu_reset got=%b exp=0", cpu_reset); end
    bus.cpu_addr = 16'hFFFC;
    bus.cpu_we   = 1'b0;
    #1;
    checks++; if (bus.ram_addr !== 16'hFFFC || bus.ram_we !== 1'b0) begin failures++; $display("FAIL mux_read addr=%h we=%b exp FFFC 0", bus.ram_addr, bus.ram_we); end
    bus.cpu_we   = 1'b1;
    bus.cpu_dout = 8'h55;
    #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_din !== 8'h55) begin failures++; $display("FAIL mux_write we=%b din=%h exp 1 55", bus.ram_we, bus.ram_din); end
    bus.cpu_we = 1'b0;
  endtask

  task automatic test_load_while_running();
    send_byte(8'h4C);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL run_load_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0 || bus.ram_we !== 1'b0) begin failures++; $display("FAIL run_load_idle busy=%b we=%b exp 0 0", busy, bus.ram_we); end
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL run_load_err_pulse got=%b exp=0", err); end
    send_byte(8'h48);
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL halt_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL halt_ram_we got=%b exp=0", bus.ram_we); end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h00);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bad_cmd err=%b busy=%b exp 1 0", err, busy); end
    tick();
  endtask

  task automatic test_wrap_zero();
    send_byte(8'h4C); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'hFFFF || bus.ram_din !== 8'h11) begin failures++; $display("FAIL wrap_first we=%b addr=%h din=%h exp 1 FFFF 11", bus.ram_we, bus.ram_addr, bus.ram_din); end
    send_byte(8'h22);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0000 || bus.ram_din !== 8'h22) begin failures++; $display("FAIL wrap_second we=%b addr=%h din=%h exp 1 0000 22", bus.ram_we, bus.ram_addr, bus.ram_din); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", load_done); end
    send_byte(8'h4C); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0 || bus.ram_we !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL zero_len[%0d] busy=%b we=%b done=%b exp 0 0 0", i, busy, bus.ram_we, load_done); end
      tick();
    end
  endtask

  task automatic test_mid_frame_cmd();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h52);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0010 || bus.ram_din !== 8'h52) begin failures++; $display("FAIL cmd_as_data we=%b addr=%h din=%h exp 1 0010 52", bus.ram_we, bus.ram_addr, bus.ram_din); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL cmd_as_data_cpu_reset got=%b exp=1", cpu_reset); end
  endtask

  task automatic test_timeout();
    bit seen;
    send_byte(8'h4C);
    send_byte(8'hC0);
    for (int i = 0; i < 15; i++) begin
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early[%0d] err=%b busy=%b exp 0 1", i, err, busy); end
      tick();
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (err === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL tmo_err got=0 exp=1 within 4 cycles"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    tick();
    send_byte(8'h4C); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h77);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h2000 || bus.ram_din !== 8'h77 || load_done !== 1'b1) begin failures++; $display("FAIL tmo_reload we=%b addr=%h din=%h done=%b exp 1 2000 77 1", bus.ram_we, bus.ram_addr, bus.ram_din, load_done); end
  endtask

  task automatic test_timeout_edge();
    send_byte(8'h4C);
    idle(15);
    send_byte(8'h30);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_edge err=%b busy=%b exp 0 1", err, busy); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h99);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h3000 || bus.ram_din !== 8'h99) begin failures++; $display("FAIL tmo_edge_write we=%b addr=%h din=%h exp 1 3000 99", bus.ram_we, bus.ram_addr, bus.ram_din); end
  endtask

  task automatic test_reset_mid_data();
    send_byte(8'h4C); send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hAA);
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'hC000) begin failures++; $display("FAIL rst_mid_first we=%b addr=%h exp 1 C000", bus.ram_we, bus.ram_addr); end
    idle(2);
    bus.rx_data  = 8'hBB;
    bus.rx_valid = 1'b1;
    reset        = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    reset        = 1'b0;
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", bus.ram_we); end
    checks++; if (busy !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL rst_mid_state busy=%b done=%b exp 0 0", busy, load_done); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_mid_cpu_reset got=%b exp=1", cpu_reset); end
    tick();
    checks++; if (bus.ram_we !== 1'b0 || load_done !== 1'b0) begin failures++; $display("FAIL rst_mid_after we=%b done=%b exp 0 0", bus.ram_we, load_done); end
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_run_mux();
    test_load_while_running();
    test_bad_cmd();
    test_wrap_zero();
    test_mid_frame_cmd();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Serial program loader sitting directly upstream of the 64 KiB system RAM.
- Consumes a byte stream from a UART receiver and decodes load/run/halt commands.
- Writes program images into RAM through the RAM's single port (addr/WE/data-in, 1-cycle synchronous read) while holding the 65C02 in reset.
- On command, hands the RAM port back to the CPU and releases its reset.

Parameters:
- BOOT_HOLD, 1: 1 = CPU held in reset after system reset until a run command arrives; 0 = CPU runs immediately.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- CMD_LOAD, 8'h4C: 'L', start a load frame.
- CMD_RUN, 8'h52: 'R', release the CPU.
- CMD_HALT, 8'h48: 'H', halt the CPU.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  single-cycle strobe, rx_data valid; no back-pressure, every strobe is consumed.
- cpu_addr  in  16  CPU address bus.
- cpu_we  in  1  CPU write enable.
- cpu_dout  in  8  CPU write data.
- cpu_reset  out  1  active-high reset to the CPU; 1 = halted, loader owns RAM.
- ram_addr  out  16  to RAM addr.
- ram_we  out  1  to RAM WE.
- ram_din  out  8  to RAM data-in.
- busy  out  1  high while a frame is in progress (state != IDLE).
- load_done  out  1  one-cycle pulse on the cycle the last data byte is written.
- err  out  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- Reset values:
  - cpu_reset = BOOT_HOLD.
  - Internal loader strobe, load_done, err, busy all 0.
  - Pointer 0, count 0, state IDLE.
- Frame format: CMD_LOAD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN data bytes. All fields are big-endian.
- States: IDLE -> AHI -> ALO -> LHI -> LLO -> DATA -> IDLE. Each transition fires on an rx_valid cycle.
- IDLE byte decode:
  - CMD_LOAD with cpu_reset=1: go to AHI.
  - CMD_LOAD with cpu_reset=0: err pulse next cycle; stay IDLE; no writes.
  - CMD_RUN: cpu_reset=0 next cycle.
  - CMD_HALT: cpu_reset=1 next cycle.
  - Any other byte: err pulse; stay IDLE.
- LLO with LEN=0: return to IDLE with no write and no load_done.
- DATA:
  - A byte at cycle N produces the internal write at cycle N+1 (ram_we=1, ram_addr=pointer, ram_din=byte, all registered).
  - The pointer increments modulo 2^16, so FFFF wraps to 0000.
  - count decrements; the write that takes count to 0 also pulses load_done and returns to IDLE.
- RAM port mux:
  - cpu_reset=1: ram_addr/ram_we/ram_din driven from the loader's registers; ram_we=0 except on write cycles.
  - cpu_reset=0: combinational passthrough of cpu_addr/cpu_we/cpu_dout.
- CMD_RUN/CMD_HALT bytes arriving mid-frame are treated as data or fields, not commands.
- Timeout:
  - A counter resets on every rx_valid and runs only while state != IDLE.
  - On reaching TIMEOUT_CYCLES: err pulse, state IDLE, partially written bytes remain in RAM.
  - The counter saturates and does not wrap.
- Simultaneous events: a timeout expiring in the same cycle as rx_valid is not a timeout; the byte is accepted.
- Reset mid-frame: state IDLE immediately, pending write suppressed (ram_we=0 in the cycle after reset), cpu_reset=BOOT_HOLD.
- RAM read data goes straight to the CPU; the loader provides no readback path.

Decomposition:
- Package ram_loader_pkg holds:
  - State enum (IDLE, AHI, ALO, LHI, LLO, DATA).
  - Default command byte constants.
  - Width of the timeout counter, derived as $clog2(TIMEOUT_CYCLES+1).
- No sub-module is required. The timeout counter stays inline.

Test Plan:
- Boot load: after reset, check cpu_reset=1, ram_we=0. Send 4C C0 00 00 03 EA A0 00. Expect writes C000=EA, C001=A0, C002=00, one per byte at N+1, with load_done on the C002 write cycle and busy falling on the same cycle.
- Run and mux: send 52. Expect cpu_reset=0 on the next cycle. Drive cpu_addr=FFFC, cpu_we=0 and expect ram_addr=FFFC, ram_we=0 on the same cycle. Drive cpu_we=1, cpu_dout=55 and expect ram_we=1, ram_din=55.
- Load while running: with cpu_reset=0, send 4C. Expect an err pulse, busy=0, and no loader write. Then send 48 and expect cpu_reset=1.
- Wrap and zero length:
  - Send 4C FF FF 00 02 11 22. Expect writes FFFF=11 then 0000=22.
  - Send 4C 12 34 00 00. Expect return to IDLE with no write and no load_done.
- Timeout (TIMEOUT_CYCLES=16): send 4C C0 then 16 idle cycles. Expect an err pulse and busy=0. A following full frame then loads correctly.
- Reset mid-DATA: after 4C C0 00 00 04 AA, assert reset on the cycle of the second data byte. Expect no write for that byte, busy=0, cpu_reset=BOOT_HOLD, and no load_done.
